// File: rtl/ysyx_22041405_if_id_buf.sv
// IF/ID pipeline register built as a two-entry skid buffer.
// The main entry drives decode. The skid entry takes one extra beat while
// decode stalls, which lets in_ready come straight from a flop.
module ysyx_22041405_if_id_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [31:0]      stall_cnt
);

    // The encoding equals the number of entries held, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic             in_ready_n;
    logic             accept, pop;
    logic             load_main, load_skid, main_from_skid;
    logic [WIDTH-1:0] skid_pc, skid_instr;

    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state and load-enable decode. Flush overrides every other case.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_n        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_n   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_n   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_n        = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
        in_ready_n = (state_n != FULL);
    end

    // State and in_ready registers. in_ready is registered, so no input reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
        if (!rst) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_n;
            in_ready <= in_ready_n;
        end
    end

    // Main entry. It always holds the oldest instruction and loads only on its load condition.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the data registers are reset too, so out_pc/out_instr read zero after reset instead of X.
        if (!rst) begin
            out_pc    <= '0;
            out_instr <= '0;
        end else if (load_main) begin
            out_pc    <= main_from_skid ? skid_pc    : in_pc;
            out_instr <= main_from_skid ? skid_instr : in_instr;
        end
    end

    // Skid entry. It catches the beat accepted while decode stalls with the main entry full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (load_skid) begin
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
        end
    end

    // Saturating decode-stall counter. Flush does not clear it; only reset does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/ysyx_22041405_if_id_buf.md
# ysyx_22041405_if_id_buf

Two-entry skid buffer forming the IF/ID pipeline register between the instruction fetch unit and the decode unit. Captures each fetched `{pc, instr}` pair under a valid/ready handshake, presents it to decode one cycle later, and absorbs one extra beat when decode stalls so that `in_ready` is a pure register output. A synchronous flush discards all buffered instructions on branch/jump redirect.

## Interface
- `WIDTH`, 32, width of PC and instruction words
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  IFU presents a fetched instruction
- `in_ready`  out  1  buffer can accept; registered, no combinational input path
- `in_pc`  in  WIDTH  PC of fetched instruction
- `in_instr`  in  WIDTH  fetched instruction word
- `out_valid`  out  1  decode-side instruction valid
- `out_ready`  in  1  IDU consumes the presented instruction
- `out_pc`  out  WIDTH  PC to decode
- `out_instr`  out  WIDTH  instruction to decode
- `flush`  in  1  discard all contents (redirect), synchronous
- `occupancy`  out  2  entries held: 0, 1 or 2
- `stall_cnt`  out  32  saturating count of cycles with `out_valid && !out_ready`

## Operation
- Storage: main entry (drives `out_*`) and skid entry; each holds pc, instr, valid bit.
- accept = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- States (encoded by valid bits, equal to `occupancy`):
  - EMPTY (0): `in_ready`=1, `out_valid`=0. accept -> ONE, main <= input.
  - ONE (1): `in_ready`=1, `out_valid`=1. accept&pop -> ONE, main <= input. accept&!pop -> FULL, skid <= input. !accept&pop -> EMPTY. neither -> hold.
  - FULL (2): `in_ready`=0, `out_valid`=1. pop -> ONE, main <= skid. !pop -> hold.
- `in_ready` next = (next state != FULL); register, updated every edge.
- Order preserved: main always holds the oldest instruction.
- `flush` has top priority: next state EMPTY, both valid bits cleared, `in_ready` next = 1. An input accepted in the flush cycle is dropped. A pop in the flush cycle is still a completed transfer for the IDU.
- Data registers need not be cleared on flush; `out_pc`/`out_instr` are don't-care while `out_valid`=0.
- Data registers load only on their load condition (no load on idle cycles).
- `stall_cnt`: increments by 1 each cycle `out_valid && !out_ready`; saturates at 32'hFFFF_FFFF; cleared only by reset, not by flush.
- `in_valid` with `in_ready`=0 is ignored; IFU must hold its data.

## Timing
- Reset (`rst`=0, asynchronous): state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_pc`=0, `out_instr`=0, `stall_cnt`=0. Release synchronous to next edge use.
- Latency: instruction accepted at edge N appears on `out_*` with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle sustained while `out_ready`=1.
- `in_ready` falls the cycle after the second unconsumed accept; rises the cycle after the pop leaving FULL.
- No combinational path from `out_ready` or `flush` to `in_ready`; `out_*` are register outputs.
- Reset asserted mid-stream: all contents lost immediately, outputs go to reset values asynchronously.

## Test plan
- Reset then stream pc=0x80000000, 0x80000004, 0x80000008 with `out_ready`=1 -> `out_pc` follows one cycle later, `occupancy`=1 throughout, `in_ready` stays 1, `stall_cnt`=0.
- Two accepts (0x80000000, 0x80000004) with `out_ready`=0 -> `occupancy`=2, `in_ready`=0 next cycle, `out_pc`=0x80000000 held; third `in_valid` ignored; raise `out_ready` -> 0x80000000 then 0x80000004 in order, `in_ready` back to 1 one cycle after first pop.
- Stall 5 cycles with `out_valid`=1, `out_ready`=0 -> `stall_cnt`=5; assert flush -> count unchanged.
- FULL state, assert `flush` with `in_valid`=1 pc=0x80000100 -> next cycle `occupancy`=0, `out_valid`=0, `in_ready`=1; 0x80000100 never appears.
- Force `stall_cnt` near saturation (0xFFFFFFFE) and stall 3 cycles -> holds 0xFFFFFFFF.
- Drop `rst` while FULL mid-cycle -> `out_valid`=0, `in_ready`=1, `occupancy`=0 without a clock edge.
